// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store bus unit: funct3 access encodings,
// FSM state enum and size decode helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2
  } lsu_size_t;

  // Any encoding outside B/H/BU/HU behaves as a word access.
  function automatic lsu_size_t f3_size(input logic [2:0] f3);
    case (f3)
      F3_B, F3_BU: return SZ_B;
      F3_H, F3_HU: return SZ_H;
      default:     return SZ_W;
    endcase
  endfunction

  function automatic logic f3_unsigned(input logic [2:0] f3);
    return (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables and data shift, plus load
// byte/half extraction with sign or zero extension.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [2:0]  i_st_funct3,
  input  logic [1:0]  i_st_lane,
  input  logic [31:0] i_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_funct3,
  input  logic [1:0]  i_ld_lane,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_rdata
);

  lsu_size_t   w_st_sz;
  lsu_size_t   w_ld_sz;
  logic [1:0]  w_st_sh;
  logic [1:0]  w_ld_sh;
  logic [31:0] w_ld_shifted;
  logic        w_ld_uns;

  always_comb begin
    w_st_sz = f3_size(i_st_funct3);
    w_st_sh = 2'b00;
    o_be    = 4'b1111;
    case (w_st_sz)
      SZ_B: begin
        w_st_sh = i_st_lane;
        o_be    = 4'b0001 << i_st_lane;
      end
      SZ_H: begin
        w_st_sh = {i_st_lane[1], 1'b0};
        o_be    = 4'b0011 << {i_st_lane[1], 1'b0};
      end
      default: ;
    endcase
    o_wdata = i_wdata << {w_st_sh, 3'b000};
  end

  always_comb begin
    w_ld_sz  = f3_size(i_ld_funct3);
    w_ld_uns = f3_unsigned(i_ld_funct3);
    w_ld_sh  = 2'b00;
    case (w_ld_sz)
      SZ_B:    w_ld_sh = i_ld_lane;
      SZ_H:    w_ld_sh = {i_ld_lane[1], 1'b0};
      default: ;
    endcase
    w_ld_shifted = i_rdata >> {w_ld_sh, 3'b000};
    o_rdata      = w_ld_shifted;
    case (w_ld_sz)
      SZ_B:    o_rdata = w_ld_uns ? {24'd0, w_ld_shifted[7:0]}
                                  : {{24{w_ld_shifted[7]}}, w_ld_shifted[7:0]};
      SZ_H:    o_rdata = w_ld_uns ? {16'd0, w_ld_shifted[15:0]}
                                  : {{16{w_ld_shifted[15]}}, w_ld_shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_bus.sv
// M-stage load/store unit bridging the pipeline to a valid/ready memory bus.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned H/W accesses without a bus cycle.
//
// state | meaning
// IDLE  | waiting for a load/store request; accepting one stalls the pipe
// BUSY  | bus_valid held with stable outputs until bus_ready or timeout
// DONE  | result visible, stall released; return to IDLE next cycle
module lsu_bus
  import lsu_pkg::*;
#(
  parameter int MAX_WAIT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] AddrM,
  input  logic [31:0] WriteDataM,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        BusErrM,
  output logic        MisalignM,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic [31:0] bus_rdata
);

  localparam int WW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WW-1:0] WAIT_INIT = WW'(MAX_WAIT - 1);

  lsu_state_t  r_state;
  logic [WW-1:0] r_wait;
  logic [31:0] r_addr;
  logic        r_we;
  logic [3:0]  r_be;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic [31:0] r_rdata;
  logic        r_buserr;

  logic        w_req;
  logic        w_skip;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_rdata_ext;

  assign w_req = MemReadM | MemWriteM;

  lsu_align u_align (
    .i_st_funct3 (funct3M),
    .i_st_lane   (AddrM[1:0]),
    .i_wdata     (WriteDataM),
    .o_be        (w_be),
    .o_wdata     (w_wdata),
    .i_ld_funct3 (r_funct3),
    .i_ld_lane   (r_addr[1:0]),
    .i_rdata     (bus_rdata),
    .o_rdata     (w_rdata_ext)
  );

`ifdef LSU_MISALIGN_CHECK_EN
  lsu_size_t w_req_sz;
  logic      r_misalign;

  assign w_req_sz = f3_size(funct3M);
  assign w_skip   = ((w_req_sz == SZ_H) && AddrM[0]) ||
                    ((w_req_sz == SZ_W) && (AddrM[1:0] != 2'b00));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_misalign <= 1'b0;
    else        r_misalign <= (r_state == ST_IDLE) && w_req && w_skip;
  end

  assign MisalignM = r_misalign;
`else
  assign w_skip    = 1'b0;
  assign MisalignM = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_wait   <= '0;
      r_addr   <= '0;
      r_we     <= 1'b0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
      r_rdata  <= '0;
      r_buserr <= 1'b0;
    end else begin
      r_buserr <= (r_state == ST_BUSY) && !bus_ready && (r_wait == '0);
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            // A simultaneous read+write request is a store.
            r_addr   <= AddrM;
            r_we     <= MemWriteM;
            r_be     <= w_be;
            r_wdata  <= w_wdata;
            r_funct3 <= funct3M;
            r_wait   <= WAIT_INIT;
            r_state  <= w_skip ? ST_DONE : ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (bus_ready) begin
            if (!r_we) r_rdata <= w_rdata_ext;
            r_state <= ST_DONE;
          end else if (r_wait == '0) begin
            r_rdata <= '0;
            r_state <= ST_DONE;
          end else begin
            r_wait <= r_wait - 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Reset gates the stall so it drops immediately even with a request pending.
  assign StallM    = rst_n && (((r_state == ST_IDLE) && w_req) || (r_state == ST_BUSY));
  assign bus_valid = (r_state == ST_BUSY);
  assign bus_we    = r_we;
  assign bus_addr  = {r_addr[31:2], 2'b00};
  assign bus_wdata = r_wdata;
  assign bus_be    = r_be;
  assign ReadDataM = r_rdata;
  assign BusErrM   = r_buserr;

endmodule

// File: tb/tb_lsu_bus.sv
// Directed bench for lsu_bus: expected load results go through a scoreboard
// queue and are checked when the unit reaches DONE.
module tb_lsu_bus;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemReadM, MemWriteM;
  logic [2:0]  funct3M;
  logic [31:0] AddrM, WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallM, BusErrM, MisalignM;
  logic        bus_valid, bus_ready, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_be;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] sb[$];
  logic [31:0] last_rd = 32'd0;

  always #5 clk = ~clk;

  lsu_bus #(.MAX_WAIT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .MemReadM(MemReadM), .MemWriteM(MemWriteM), .funct3M(funct3M),
    .AddrM(AddrM), .WriteDataM(WriteDataM), .ReadDataM(ReadDataM),
    .StallM(StallM), .BusErrM(BusErrM), .MisalignM(MisalignM),
    .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_rdata(bus_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sb_check(input string tag);
    logic [31:0] exp;
    if (sb.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      exp = sb.pop_front();
      chk(tag, ReadDataM, exp);
    end
  endtask

  // One accepted access with bus_ready in the n_busy-th BUSY cycle.
  task automatic xact(input string tag, input logic rd, input logic wr,
                      input logic [2:0] f3, input logic [31:0] addr,
                      input logic [31:0] wd, input int n_busy,
                      input logic [31:0] rdata, input logic [31:0] exp_rd,
                      input logic [31:0] exp_addr, input logic [3:0] exp_be,
                      input logic [31:0] wd_mask, input logic [31:0] exp_wd);
    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; funct3M = f3; AddrM = addr; WriteDataM = wd;
    bus_ready = 1'b0;
    if (wr) sb.push_back(last_rd);
    else begin sb.push_back(exp_rd); last_rd = exp_rd; end
    #1;
    chk({tag, "_req_stall"}, {31'd0, StallM}, 32'd1);
    chk({tag, "_req_novalid"}, {31'd0, bus_valid}, 32'd0);
    for (int i = 0; i < n_busy; i++) begin
      @(negedge clk);
      bus_ready = (i == n_busy - 1);
      bus_rdata = rdata;
      #1;
      chk({tag, "_busy_valid"}, {31'd0, bus_valid}, 32'd1);
      chk({tag, "_busy_stall"}, {31'd0, StallM}, 32'd1);
      chk({tag, "_bus_addr"}, bus_addr, exp_addr);
      chk({tag, "_bus_be"}, {28'd0, bus_be}, {28'd0, exp_be});
      chk({tag, "_bus_we"}, {31'd0, bus_we}, {31'd0, wr});
      if (wr) chk({tag, "_bus_wdata"}, bus_wdata & wd_mask, exp_wd);
    end
    @(negedge clk);
    bus_ready = 1'b0;
    #1;
    chk({tag, "_done_stall"}, {31'd0, StallM}, 32'd0);
    chk({tag, "_done_valid"}, {31'd0, bus_valid}, 32'd0);
    chk({tag, "_done_buserr"}, {31'd0, BusErrM}, 32'd0);
    sb_check({tag, "_rdata"});
    @(negedge clk);
    MemReadM = 1'b0; MemWriteM = 1'b0;
    #1;
    chk({tag, "_idle_valid"}, {31'd0, bus_valid}, 32'd0);
    chk({tag, "_idle_stall"}, {31'd0, StallM}, 32'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; MemReadM = 1'b0; MemWriteM = 1'b0; funct3M = 3'b000;
    AddrM = '0; WriteDataM = '0; bus_ready = 1'b0; bus_rdata = '0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_stall", {31'd0, StallM}, 32'd0);
    chk("rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("rst_buserr", {31'd0, BusErrM}, 32'd0);
    chk("rst_misalign", {31'd0, MisalignM}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    xact("lw", 1, 0, 3'b010, 32'h100, 0, 2, 32'hDEADBEEF, 32'hDEADBEEF,
         32'h100, 4'b1111, 0, 0);
    xact("lb", 1, 0, 3'b000, 32'h103, 0, 1, 32'h80FFFFFF, 32'hFFFFFF80,
         32'h100, 4'b1000, 0, 0);
    xact("lbu", 1, 0, 3'b100, 32'h103, 0, 3, 32'h80FFFFFF, 32'h00000080,
         32'h100, 4'b1000, 0, 0);
    xact("sh", 1, 1, 3'b001, 32'h202, 32'h1234ABCD, 2, 32'hFFFFFFFF, 0,
         32'h200, 4'b1100, 32'hFFFF0000, 32'hABCD0000);
    xact("lh", 1, 0, 3'b001, 32'h302, 0, 1, 32'h80017F7F, 32'hFFFF8001,
         32'h300, 4'b1100, 0, 0);
    xact("lhu", 1, 0, 3'b101, 32'h300, 0, 1, 32'h12348001, 32'h00008001,
         32'h300, 4'b0011, 0, 0);
    xact("lb_lane1", 1, 0, 3'b000, 32'h305, 0, 1, 32'h00007F00, 32'h0000007F,
         32'h304, 4'b0010, 0, 0);
    xact("rsv_f3", 1, 0, 3'b111, 32'h10C, 0, 1, 32'hCAFEF00D, 32'hCAFEF00D,
         32'h10C, 4'b1111, 0, 0);
    xact("sb", 0, 1, 3'b000, 32'h301, 32'h000000A5, 1, 0, 0,
         32'h300, 4'b0010, 32'h0000FF00, 32'h0000A500);

    // Timeout: bus_ready never comes.
    @(negedge clk);
    MemReadM = 1'b1; funct3M = 3'b010; AddrM = 32'h400; bus_ready = 1'b0;
    sb.push_back(32'd0); last_rd = 32'd0;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (bus_valid) n++;
      else break;
    end
    chk("to_busy_cycles", n, 32'd16);
    chk("to_buserr", {31'd0, BusErrM}, 32'd1);
    chk("to_stall", {31'd0, StallM}, 32'd0);
    sb_check("to_rdata");
    @(negedge clk);
    MemReadM = 1'b0;
    #1;
    chk("to_buserr_pulse", {31'd0, BusErrM}, 32'd0);

    xact("lw2", 1, 0, 3'b010, 32'h500, 0, 1, 32'h13579BDF, 32'h13579BDF,
         32'h500, 4'b1111, 0, 0);

    // Reset in the third BUSY cycle.
    @(negedge clk);
    MemReadM = 1'b1; funct3M = 3'b010; AddrM = 32'h600; bus_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("mid_valid_pre", {31'd0, bus_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, bus_valid}, 32'd0);
    chk("mid_rst_stall", {31'd0, StallM}, 32'd0);
    chk("mid_rst_rdata", ReadDataM, 32'd0);
    last_rd = 32'd0;
    @(negedge clk);
    MemReadM = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("mid_idle_valid", {31'd0, bus_valid}, 32'd0);
    chk("mid_idle_stall", {31'd0, StallM}, 32'd0);

`ifdef LSU_MISALIGN_CHECK_EN
    @(negedge clk);
    MemReadM = 1'b1; funct3M = 3'b010; AddrM = 32'h101;
    sb.push_back(last_rd);
    #1;
    chk("mis_req_stall", {31'd0, StallM}, 32'd1);
    chk("mis_req_valid", {31'd0, bus_valid}, 32'd0);
    @(negedge clk);
    #1;
    chk("mis_pulse", {31'd0, MisalignM}, 32'd1);
    chk("mis_novalid", {31'd0, bus_valid}, 32'd0);
    chk("mis_stall", {31'd0, StallM}, 32'd0);
    sb_check("mis_rdata");
    @(negedge clk);
    MemReadM = 1'b0;
    #1;
    chk("mis_pulse_end", {31'd0, MisalignM}, 32'd0);
`else
    xact("lw_unaligned", 1, 0, 3'b010, 32'h101, 0, 1, 32'h89ABCDEF, 32'h89ABCDEF,
         32'h100, 4'b1111, 0, 0);
    chk("no_misalign", {31'd0, MisalignM}, 32'd0);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
